pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the pipelined core's IF stage. It replaces the bare
//  PC+4 adder with a registered PC, which adds boot sequencing, stall hold and redirect from EX.
//  It also has a valid/ready handshake to instruction fetch and counts accepted fetches.
// PARAMETERS
//  XLEN       32           PC / address width in bits
//  RESET_VEC  32'h0000_0000 PC value loaded on reset (XLEN wide)
//  CNT_W      16           width of accepted-fetch counter
// PORTS
//  clk_i          in   1     core clock, all state on rising edge
//  rst_ni         in   1     asynchronous, active-low reset
//  stall_i        in   1     hazard-unit stall request (hold PC)
//  redirect_i     in   1     branch/jump taken or trap; 1-cycle pulse from EX
//  redirect_pc_i  in   XLEN  redirect target, sampled when redirect_i=1
//  fetch_ready_i  in   1     IMEM/IF accepts pc_o this cycle
//  compressed_i   in   1     current instr is 16-bit (only with PC_RVC_EN)
//  pc_o           out  XLEN  current fetch PC
//  pc_plus_o      out  XLEN  pc_o + INC (combinational, link value for JAL/JALR)
//  pc_valid_o     out  1     pc_o is a valid fetch request
//  misalign_o     out  1     1-cycle pulse: redirect target was misaligned
//  fetch_cnt_o    out  CNT_W number of accepted fetches (valid && ready)
// BEHAVIOUR
//  - Reset (rst_ni=0, async): pc_o=RESET_VEC, pc_valid_o=0, misalign_o=0, fetch_cnt_o=0, state=BOOT.
//  - INC=4. With PC_RVC_EN, INC = compressed_i ? 2 : 4. ALIGN mask = 2'b11 (4-byte) or 2'b01 (RVC).
//  - Arithmetic is unsigned mod 2^XLEN. The PC wraps from 2^XLEN-4 to 0 with no flag.
//    fetch_cnt_o wraps to 0.
//  - FSM states: BOOT, RUN, HOLD.
//    BOOT: pc_valid_o=0 for exactly one cycle after rst_ni deasserts, then RUN (pc_o=RESET_VEC).
//    RUN : pc_valid_o=1. If fetch_ready_i && !stall_i then pc_o <= pc_o+INC next cycle.
//          If stall_i then HOLD.
//    HOLD: pc_valid_o=0 and pc_o held. Returns to RUN on the first cycle with stall_i=0.
//          pc_o is unchanged on re-entry.
//  - Handshake: while pc_valid_o=1 && fetch_ready_i=0, pc_o is held stable.
//    An accepted fetch is valid && ready && !stall_i in RUN. Each accepted fetch increments fetch_cnt_o by 1.
//  - Redirect has the highest priority in every state, including BOOT. It overrides stall and ready.
//    On redirect_i=1: next cycle pc_o = redirect_pc_i & ~ALIGN. Next state is HOLD if stall_i=1, else RUN.
//    The fetch in the redirect cycle is not counted, even if fetch_ready_i=1.
//  - Misalignment: if (redirect_pc_i & ALIGN)!=0 on a redirect, misalign_o=1 for the following cycle only.
//    pc_o still loads the cleared-bit target. The trap itself is handled downstream.
//  - Back-to-back redirects: each one is honoured and the last one wins. No queuing.
//  - Latency: stall and redirect act on the next edge. pc_plus_o has zero latency from pc_o.
//  - Reset asserted mid-operation aborts everything immediately and returns to BOOT values.
// CONFIGURATION
//  PC_RVC_EN defined: compressed_i is used, INC is 2 or 4, and 2-byte alignment applies.
//  PC_RVC_EN undefined: the compressed_i port is absent, INC is fixed at 4,
//    and 4-byte alignment applies (redirect bit1 set -> misalign_o).
// TESTING
//  1 Reset release, ready=1 -> cycle0 valid=0, then pc_o=0x0,0x4,0x8,0xC; fetch_cnt_o=3 after 4 cycles.
//  2 stall_i=1 for 3 cycles at pc=0x10 -> valid=0, pc_o=0x10 held; after release pc=0x10 then 0x14.
//  3 ready=0 for 2 cycles at pc=0x20 -> pc_o held at 0x20, valid=1, fetch_cnt_o unchanged.
//  4 redirect_i with target 0x100 while stall_i=1 -> next pc_o=0x100 in HOLD, no count; stall drops -> 0x104.
//  5 redirect target 0x202 (no RVC) -> pc_o=0x200, misalign_o=1 for exactly one cycle.
//    With PC_RVC_EN: pc_o=0x202, no flag. Then compressed_i=1 gives next pc 0x204.
//  6 XLEN=32, pc=0xFFFF_FFFC accepted -> pc_o=0x0. Assert rst_ni=0 mid-stream -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: control inputs from hazard/EX and the PC handshake to IF.
// Optional compressed_i exists only when PC_RVC_EN is defined.
interface pc_gen_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // Handshake: a fetch transfers on a rising edge where pc_valid_o=1 and fetch_ready_i=1
  // (and no stall/redirect); while valid is high and ready is low, pc_o stays stable.
  logic             stall_i;
  logic             redirect_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic             fetch_ready_i;
`ifdef PC_RVC_EN
  logic             compressed_i;
`endif
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  pc_plus_o;
  logic             pc_valid_o;
  logic             misalign_o;
  logic [CNT_W-1:0] fetch_cnt_o;

`ifdef PC_RVC_EN
  modport master (
    input  stall_i, redirect_i, redirect_pc_i, fetch_ready_i, compressed_i,
    output pc_o, pc_plus_o, pc_valid_o, misalign_o, fetch_cnt_o
  );
  modport slave (
    output stall_i, redirect_i, redirect_pc_i, fetch_ready_i, compressed_i,
    input  pc_o, pc_plus_o, pc_valid_o, misalign_o, fetch_cnt_o
  );
`else
  modport master (
    input  stall_i, redirect_i, redirect_pc_i, fetch_ready_i,
    output pc_o, pc_plus_o, pc_valid_o, misalign_o, fetch_cnt_o
  );
  modport slave (
    output stall_i, redirect_i, redirect_pc_i, fetch_ready_i,
    input  pc_o, pc_plus_o, pc_valid_o, misalign_o, fetch_cnt_o
  );
`endif
endinterface

// File: rtl/pc_gen.sv
// Registered program-counter generator for the IF stage: boot, stall hold, EX redirect, fetch count.
// Define PC_RVC_EN to enable compressed (2-byte) increments and 2-byte alignment.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              CNT_W     = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  pc_gen_if.master   bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

`ifdef PC_RVC_EN
  localparam logic [XLEN-1:0] ALIGN = XLEN'(2'b01);
`else
  localparam logic [XLEN-1:0] ALIGN = XLEN'(2'b11);
`endif

  state_e           state_q;
  logic [XLEN-1:0]  pc_q;
  logic             valid_q;
  logic             misalign_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  inc;

  always_comb begin
`ifdef PC_RVC_EN
    inc = bus.compressed_i ? XLEN'(2) : XLEN'(4);
`else
    inc = XLEN'(4);
`endif
  end

  // Redirect is checked ahead of the state case so it wins in every state, BOOT included.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      misalign_q <= 1'b0;
      if (bus.redirect_i) begin
        pc_q       <= bus.redirect_pc_i & ~ALIGN;
        misalign_q <= |(bus.redirect_pc_i & ALIGN);
        state_q    <= bus.stall_i ? HOLD : RUN;
        valid_q    <= !bus.stall_i;
      end else begin
        case (state_q)
          BOOT: begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end
          RUN: begin
            if (bus.stall_i) begin
              state_q <= HOLD;
              valid_q <= 1'b0;
            end else if (bus.fetch_ready_i) begin
              pc_q  <= pc_q + inc;
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HOLD: begin
            if (!bus.stall_i) begin
              state_q <= RUN;
              valid_q <= 1'b1;
            end
          end
          default: begin
            state_q <= BOOT;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.pc_plus_o   = pc_q + inc;
  assign bus.pc_valid_o  = valid_q;
  assign bus.misalign_o  = misalign_q;
  assign bus.fetch_cnt_o = cnt_q;
  assign state_o         = state_q;

endmodule
